// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider width, divide-by-zero quotient, FSM states.
package alu_pkg;

  localparam int DIV_WIDTH = 32;

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_32_trial_sub.sv
// Trial subtractor for restoring division: rem - divisor, built as an add of
// the inverted divisor with carry-in 1, the same way the carry-in adder works.
module div_trial_sub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] sum;

  // {1'b1, ~divisor} is the bitwise inverse of the zero-extended divisor.
  assign sum    = rem + {1'b1, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
  assign diff   = sum[WIDTH-1:0];
  // Top bit set means the trial went negative, so the remainder is restored.
  assign borrow = sum[WIDTH];

endmodule

// File: rtl/div_32.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per cycle.
module div_32
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude shifting into quotient
  logic [WIDTH-1:0] dsr_q, dsr_d;     // divisor magnitude
  logic [WIDTH-1:0] num_q, num_d;     // raw dividend, returned on divide-by-zero
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_borrow;

  assign shifted = {rem_q, dvd_q[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .rem     (shifted),
    .divisor (dsr_q),
    .diff    (trial_diff),
    .borrow  (trial_borrow)
  );

  // Next-state and datapath logic; result registers load only in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    num_d   = num_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          num_d   = dividend;
          zero_d  = (divisor == '0);
          qneg_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_d  = is_signed & dividend[WIDTH-1];
          dvd_d   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
          dsr_d   = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        rem_d = trial_borrow ? shifted[WIDTH-1:0] : trial_diff;
        dvd_d = {dvd_q[WIDTH-2:0], ~trial_borrow};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        dvd_d   = qneg_q ? -dvd_q : dvd_q;
        rem_d   = rneg_q ? -rem_q : rem_q;
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        quot_d  = zero_q ? DIV_ZERO_QUOT : dvd_q;
        remo_d  = zero_q ? num_q : rem_q;
        dbz_d   = zero_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      num_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      num_q   <= num_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule
